// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage and its request FIFO.
package alu_pkg;

  localparam int ALU_W = 6;
  localparam int OP_W  = 2;
  localparam int TAG_W = 4;

  localparam logic [OP_W-1:0] OP_SHIFT_PLUS = 2'b00;
  localparam logic [OP_W-1:0] OP_A_PLUS_3B  = 2'b01;
  localparam logic [OP_W-1:0] OP_B_INVERSE  = 2'b10;
  localparam logic [OP_W-1:0] OP_ABS        = 2'b11;

  // One queued operation request.
  typedef struct packed {
    logic signed [ALU_W-1:0] a;
    logic signed [ALU_W-1:0] b;
    logic [OP_W-1:0]         op;
    logic [TAG_W-1:0]        tag;
  } alu_req_t;

  // Output stage occupancy.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 6-bit signed ALU; every result wraps modulo 64.
module ALU
  import alu_pkg::*;
(
  input  logic signed [ALU_W-1:0] A,
  input  logic signed [ALU_W-1:0] B,
  input  logic [OP_W-1:0]         Operator,
  output logic signed [ALU_W-1:0] Out
);

  // Operator decode; all intermediate sums are kept at ALU_W bits so they wrap.
  always_comb begin
    Out = '0;
    case (Operator)
      OP_SHIFT_PLUS: Out = (A <<< 1) + B;
      OP_A_PLUS_3B:  Out = A + (B <<< 1) + B;
      OP_B_INVERSE:  Out = -B;
      OP_ABS:        Out = A[ALU_W-1] ? -A : A;
      default:       Out = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit_op_fifo.sv
// Request FIFO: power-of-two depth, synchronous flush, non-popping head read.
module op_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  alu_req_t                 wr_data,
  output alu_req_t                 head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  alu_req_t         mem_reg [DEPTH];

  logic push_ok;
  logic pop_ok;

  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign push_ok = push && (count_reg != CNT_W'(DEPTH)) && !flush;
  assign pop_ok  = pop && (count_reg != '0) && !flush;

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

  // Occupancy update: simultaneous push and pop cancel out.
  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  // Entry storage; contents need no reset since count gates their use.
  always_ff @(posedge clk) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage: request FIFO feeding a combinational ALU, result captured
// into a handshaked output register together with its tag and flags.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_W-1:0]         in_a,
  input  logic [ALU_W-1:0]         in_b,
  input  logic [OP_W-1:0]          in_op,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALU_W-1:0]         out_data,
  output logic [OP_W-1:0]          out_op,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               done_count
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  alu_req_t          wr_req;
  alu_req_t          fifo_head;
  alu_req_t          alu_req;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic signed [ALU_W-1:0] alu_out;

  out_state_t        state_reg;
  out_state_t        state_next;

  logic [ALU_W-1:0]  out_data_reg;
  logic [OP_W-1:0]   out_op_reg;
  logic [TAG_W-1:0]  out_tag_reg;
  logic              out_zero_reg;
  logic              out_neg_reg;
  logic [7:0]        done_count_reg;

  logic load;
  logic deliver;

  assign wr_req = '{a: $signed(in_a), b: $signed(in_b), op: in_op, tag: in_tag};

  op_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (in_valid && in_ready),
    .pop     (load),
    .wr_data (wr_req),
    .head    (fifo_head),
    .count   (fifo_count)
  );

  // in_ready depends on occupancy only, never on in_valid.
  assign fifo_empty = (fifo_count == '0);
  assign in_ready   = (fifo_count != CNT_W'(DEPTH));
  assign count      = fifo_count;

  // Idle ALU sees zeros rather than stale FIFO contents.
  assign alu_req = fifo_empty ? '0 : fifo_head;

  ALU u_alu (
    .A        (alu_req.a),
    .B        (alu_req.b),
    .Operator (alu_req.op),
    .Out      (alu_out)
  );

  assign out_valid = (state_reg == OUT_HOLD);
  assign load      = !fifo_empty && (!out_valid || out_ready) && !flush;
  assign deliver   = out_valid && out_ready && !flush;

  // Output stage next-state: flush wins, then load, then drain.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = OUT_EMPTY;
    end else begin
      case (state_reg)
        OUT_EMPTY: if (load) state_next = OUT_HOLD;
        OUT_HOLD:  if (!load && out_ready) state_next = OUT_EMPTY;
        default:   state_next = OUT_EMPTY;
      endcase
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= OUT_EMPTY;
    else        state_reg <= state_next;
  end

  // Result register; fields change only on load, so they hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg <= '0;
      out_op_reg   <= '0;
      out_tag_reg  <= '0;
      out_zero_reg <= 1'b0;
      out_neg_reg  <= 1'b0;
    end else if (load) begin
      out_data_reg <= alu_out;
      out_op_reg   <= alu_req.op;
      out_tag_reg  <= alu_req.tag;
      out_zero_reg <= (alu_out == '0);
      out_neg_reg  <= alu_out[ALU_W-1];
    end
  end

  // Delivered-result counter; wraps at 256 and is untouched by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       done_count_reg <= '0;
    else if (deliver) done_count_reg <= done_count_reg + 8'd1;
  end

  assign out_data   = out_data_reg;
  assign out_op     = out_op_reg;
  assign out_tag    = out_tag_reg;
  assign out_zero   = out_zero_reg;
  assign out_neg    = out_neg_reg;
  assign done_count = done_count_reg;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit: latency, flags, backpressure, stall
// stability, flush and asynchronous reset.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_a = '0;
  logic [5:0]  in_b = '0;
  logic [1:0]  in_op = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_data;
  logic [1:0]  out_op;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_neg;
  logic [2:0]  count;
  logic [7:0]  done_count;

  int total = 0;
  int bad = 0;
  int exp_done = 0;

  int s_a   [8];
  int s_b   [8];
  int s_op  [8];
  int s_tag [8];
  int s_exp [8];

  alu_issue_unit #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_op     (out_op),
    .out_tag    (out_tag),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .count      (count),
    .done_count (done_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sdata();
    return int'($signed(out_data));
  endfunction

  // One request into an idle unit with out_ready high: check latency and result.
  task automatic run_single(input int a, input int b, input int op, input int tag,
                            input int exp_data, input int exp_zero, input int exp_neg,
                            input string name);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 6'(a);
    in_b      = 6'(b);
    in_op     = 2'(op);
    in_tag    = 4'(tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({name, "_valid_k"}, int'(out_valid), 0);
    check({name, "_count_k"}, int'(count), 1);
    @(posedge clk); #1;
    check({name, "_valid_k1"}, int'(out_valid), 1);
    check({name, "_data"}, sdata(), exp_data);
    check({name, "_zero"}, int'(out_zero), exp_zero);
    check({name, "_neg"}, int'(out_neg), exp_neg);
    check({name, "_tag"}, int'(out_tag), tag);
    check({name, "_op"}, int'(out_op), op);
    $display("result %s: tag=%0d data=%0d zero=%0d neg=%0d", name, out_tag, sdata(), out_zero, out_neg);
    @(posedge clk); #1;
    exp_done++;
    check({name, "_drained"}, int'(out_valid), 0);
    check({name, "_done"}, int'(done_count), exp_done);
  endtask

  // Stream table s_* through the unit; mode 0 ready high, 1 toggling, 2 stalled then high.
  task automatic run_stream(input int n, input int mode, input string name);
    int  sent = 0;
    int  got = 0;
    int  cyc = 0;
    logic acc;
    logic del;
    while (got < n && cyc < 200) begin
      in_valid = (sent < n);
      if (sent < n) begin
        in_a   = 6'(s_a[sent]);
        in_b   = 6'(s_b[sent]);
        in_op  = 2'(s_op[sent]);
        in_tag = 4'(s_tag[sent]);
      end
      case (mode)
        1:       out_ready = (cyc % 2 == 1);
        2:       out_ready = (cyc >= 7);
        default: out_ready = 1'b1;
      endcase
      if (mode == 2 && cyc == 5) begin
        check({name, "_full_ready"}, int'(in_ready), 0);
        check({name, "_full_count"}, int'(count), 4);
        check({name, "_accepted"}, sent, 5);
        check({name, "_held_tag"}, int'(out_tag), 0);
      end
      if (out_valid) begin
        check({name, "_tag"}, int'(out_tag), s_tag[got]);
        check({name, "_data"}, sdata(), s_exp[got]);
      end
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) $display("deliver %s: tag=%0d data=%0d", name, out_tag, sdata());
      @(posedge clk); #1;
      if (acc) sent++;
      if (del) got++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({name, "_delivered"}, got, n);
  endtask

  initial begin
    // Reset values while rst_n is held low.
    #2;
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_tag", int'(out_tag), 0);
    check("rst_op", int'(out_op), 0);
    check("rst_flags", int'({out_zero, out_neg}), 0);
    check("rst_count", int'(count), 0);
    check("rst_done", int'(done_count), 0);
    check("rst_in_ready", int'(in_ready), 1);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 12 + 3*8 = 36 wraps to -28.
    run_single(12, 8, 1, 3, -28, 0, 1, "a3b");
    run_single(-9, 2, 3, 5, 9, 0, 0, "abs9");
    run_single(0, 2, 3, 6, 0, 1, 0, "abs0");

    // Backpressure: a=t, b=1, op A+3B -> t+3; tags 0..6.
    s_a   = '{0, 1, 2, 3, 4, 5, 6, 0};
    s_b   = '{1, 1, 1, 1, 1, 1, 1, 0};
    s_op  = '{1, 1, 1, 1, 1, 1, 1, 0};
    s_tag = '{0, 1, 2, 3, 4, 5, 6, 0};
    s_exp = '{3, 4, 5, 6, 7, 8, 9, 0};
    run_stream(7, 2, "bp");
    exp_done += 7;
    check("bp_done", int'(done_count), exp_done);

    // Toggling out_ready: a=20+t, b=5 -> 35+t wraps to t-29.
    s_a   = '{20, 21, 22, 23, 24, 25, 0, 0};
    s_b   = '{5, 5, 5, 5, 5, 5, 0, 0};
    s_op  = '{1, 1, 1, 1, 1, 1, 0, 0};
    s_tag = '{8, 9, 10, 11, 12, 13, 0, 0};
    s_exp = '{-29, -28, -27, -26, -25, -24, 0, 0};
    run_stream(6, 1, "tog");
    exp_done += 6;
    check("tog_done", int'(done_count), exp_done);

    // Flush with three requests buffered; the flushed cycle offers a push and a delivery.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a     = 6'(i);
      in_b     = '0;
      in_op    = 2'd1;
      in_tag   = 4'(i);
      @(posedge clk); #1;
    end
    check("pre_flush_count", int'(count), 2);
    check("pre_flush_valid", int'(out_valid), 1);
    flush     = 1'b1;
    in_tag    = 4'd7;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("flush_valid", int'(out_valid), 0);
    check("flush_count", int'(count), 0);
    check("flush_done", int'(done_count), exp_done);
    check("flush_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    check("flush_stays_empty", int'(out_valid), 0);
    $display("flush: count=%0d done=%0d", count, done_count);

    // Asynchronous reset between edges with two requests buffered.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = 6'd1;
      in_b     = 6'd1;
      in_op    = 2'd1;
      in_tag   = 4'(i + 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("pre_rst_valid", int'(out_valid), 1);
    check("pre_rst_count", int'(count), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", int'(out_valid), 0);
    check("arst_count", int'(count), 0);
    check("arst_in_ready", int'(in_ready), 1);
    check("arst_done", int'(done_count), 0);
    check("arst_tag", int'(out_tag), 0);
    #1 rst_n = 1'b1;
    exp_done = 0;
    @(posedge clk); #1;
    // -5 + 3*(-3) = -14.
    run_single(-5, -3, 1, 9, -14, 0, 1, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Request-buffering and result-capture stage wrapped around the team's 6-bit signed `ALU` (ports A, B, Operator, Out). It accepts operation requests over a valid/ready handshake into a small FIFO. It drives the head request into the combinational ALU and registers the result with its tag and flags into an output stage that has its own valid/ready handshake. It decouples request producers from result consumers and sustains one operation per cycle.

## Interface
- DEPTH, 4, request FIFO entries; power of two, at least 2
- clk  input  1  rising-edge clock
- rst_n  input  1  reset; one clock, asynchronous, active-low
- flush  input  1  synchronous clear of FIFO and output stage
- in_valid  input  1  request present
- in_ready  output  1  FIFO can accept; equals (count != DEPTH)
- in_a  input  6  signed operand A
- in_b  input  6  signed operand B
- in_op  input  2  ALU operator code
- in_tag  input  4  opaque request ID, returned with result
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer takes result
- out_data  output  6  signed ALU result
- out_op  output  2  operator that produced out_data
- out_tag  output  4  tag of that request
- out_zero  output  1  out_data == 0
- out_neg  output  1  out_data[5]
- count  output  $clog2(DEPTH)+1  FIFO occupancy; excludes output register
- done_count  output  8  results delivered (out_valid & out_ready); wraps 255→0

## Operation
- Push: when in_valid & in_ready at an edge, {a,b,op,tag} is written at the write pointer. Pointers wrap modulo DEPTH.
- The FIFO head drives ALU A/B/Operator combinationally. When the FIFO is empty, the ALU inputs are zero.
- Load: when count != 0 and (!out_valid | out_ready), the output register captures {ALU Out, head op, head tag, zero, neg}, the head pops and out_valid is set.
- Drain: when out_valid & out_ready and no load occurs, out_valid clears.
- Output fields hold stable while out_valid & !out_ready.
- Push and pop in the same cycle leave count unchanged.
- When full, in_ready is low even if a pop occurs that cycle. There is no same-cycle pass-through.
- Total buffering is DEPTH+1 requests: FIFO plus output register.
- Ordering: results leave in strict acceptance order.
- flush: at the edge it clears the pointers, count and out_valid. It ignores any push and any delivery in that cycle. done_count is not incremented by a flushed cycle, and done_count keeps its value.
- Arithmetic is entirely inside ALU: a 6-bit two's-complement result that wraps modulo 64. This block never widens or saturates.
- Output stage states: EMPTY (out_valid=0) and HOLD (out_valid=1).
  - EMPTY→HOLD on load.
  - HOLD→HOLD on load, or on stall.
  - HOLD→EMPTY on delivery without load, or on flush.

## Timing
- Reset (asynchronous, takes effect immediately):
  - out_valid=0; out_data, out_op, out_tag, out_zero and out_neg all 0.
  - count=0, done_count=0, pointers 0.
  - in_ready=1 as soon as reset takes effect.
- Latency: a request accepted at edge k into an empty FIFO with a free output stage appears with out_valid=1 after edge k+1.
- Throughput: one result per cycle with in_valid and out_ready held high.
- in_ready is a combinational function of count only, not of in_valid.
- Reset mid-operation discards all queued and held requests, with no partial output.

## Structure
- Shared package alu_pkg:
  - ALU_W=6, OP_W=2, TAG_W=4.
  - Operator constants OP_SHIFT_PLUS=2'b00, OP_A_PLUS_3B=2'b01, OP_B_INVERSE=2'b10, OP_ABS=2'b11.
  - Request struct {a, b, op, tag}.
- One sub-module, op_fifo: parameterised DEPTH synchronous FIFO with flush, count, and head read that does not pop.
- ALU is instantiated as-is.
- The output register, flags and done_count are in the top level.

## Test plan
- Single request: in_a=12, in_b=8, in_op=01, in_tag=3. Expect out_valid one edge after acceptance, with out_data=-28 (6'b100100), out_neg=1, out_zero=0, out_tag=3.
- Absolute value: in_a=-9, in_b=2, in_op=11. Expect out_data=9 and out_neg=0. Then in_a=0, in_op=11. Expect out_data=0 and out_zero=1.
- Backpressure: hold out_ready=0 and push tags 0..6 back-to-back.
  - Tags 0..4 are accepted; in_ready goes low with count=4 and tag 5 stalls.
  - Raise out_ready. Tags 0..6 then deliver in order, one per cycle, and done_count=7.
- Stall stability: out_ready toggles 0/1 every cycle during a stream. Each result is held unchanged until taken, with no loss or duplication.
- Flush: queue 3 requests, then pulse flush with out_ready=0. Next cycle out_valid=0, count=0, done_count unchanged, and in_ready=1.
- Asynchronous reset: with 2 requests queued, drop rst_n between edges. out_valid and count go to 0 with no clock edge, and the next accepted request after release is delivered correctly.
